// File: rtl/tcb_bist_pkg.sv
// Shared types and helpers for the TCB manager BIST.
//   state_t   : pass sequencer states
//   trk_t     : response tracking entry {vld, ren, word index}
//   PKW       : width of the pattern key (word index nibble, or LFSR state)
//   pat_byte  : fixed byte pattern {n[3:0], b[3:0]}
//   lfsr_next : one step of the 32-bit Galois LFSR
// Optional feature macro: TCB_BIST_LFSR_EN (LFSR data pattern instead of fixed bytes).
package tcb_bist_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    // Word index width carried through the tracking pipeline (WRD <= 2**NW).
    localparam int NW = 16;

    typedef struct packed {
        logic          vld;
        logic          ren;
        logic [NW-1:0] n;
    } trk_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

`ifdef TCB_BIST_LFSR_EN
    localparam int PKW = 32;
`else
    localparam int PKW = 4;
`endif

    function automatic logic [7:0] pat_byte(input logic [3:0] n, input logic [3:0] b);
        return {n, b};
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/tcb_bist_pat.sv
// Pattern generator: maps a key to a DAT-bit data word.
//   key : word index nibble (fixed pattern) or LFSR state (TCB_BIST_LFSR_EN)
//   pat : DAT-bit pattern word
// Optional feature macro: TCB_BIST_LFSR_EN.
module tcb_bist_pat
    import tcb_bist_pkg::*;
#(
    parameter int DAT = 32
)(
    input  logic [PKW-1:0] key,
    output logic [DAT-1:0] pat
);

    for (genvar b = 0; b < DAT/8; b++) begin : g_byte
`ifdef TCB_BIST_LFSR_EN
        // LFSR state replicated (or truncated) across the data width.
        for (genvar i = 0; i < 8; i++) begin : g_bit
            assign pat[8*b+i] = key[(8*b+i) % 32];
        end
`else
        assign pat[8*b +: 8] = pat_byte(key, 4'(b));
`endif
    end

endmodule

// File: rtl/tcb_bist_man.sv
// TCB manager BIST: writes WRD pattern words from base, reads them back,
// counts mismatches / error responses.
//   clk, rst (async, active-low)
//   start, idl, base          : pass control, idl/base sampled at accepted start
//   busy, done, err_cnt, err_adr : pass status
//   tcb_*                     : TCB manager request/response port
// Optional feature macro: TCB_BIST_LFSR_EN (LFSR data pattern).
module tcb_bist_man
    import tcb_bist_pkg::*;
#(
    parameter  int DLY = 1,
    parameter  int ADR = 32,
    parameter  int DAT = 32,
    parameter  int WRD = 16,
    parameter  int IDW = 4,
    localparam int BEN = DAT/8,
    localparam int SZW = $clog2($clog2(BEN)+1)
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [IDW-1:0] idl,
    input  logic [ADR-1:0] base,
    output logic           busy,
    output logic           done,
    output logic [15:0]    err_cnt,
    output logic [ADR-1:0] err_adr,
    output logic           tcb_vld,
    input  logic           tcb_rdy,
    output logic           tcb_wen,
    output logic           tcb_ren,
    output logic [ADR-1:0] tcb_adr,
    output logic [SZW-1:0] tcb_siz,
    output logic [BEN-1:0] tcb_ben,
    output logic [DAT-1:0] tcb_wdt,
    input  logic [DAT-1:0] tcb_rdt,
    input  logic           tcb_sts
);

    state_t         state_q, state_d;
    logic           vld_q, vld_d, wen_q, wen_d, done_q, done_d;
    logic [ADR-1:0] adr_q, adr_d, base_q, base_d, err_adr_q, err_adr_d;
    logic [NW-1:0]  n_q, n_d;
    logic [IDW-1:0] gap_q, gap_d, idl_q, idl_d;
    logic [15:0]    err_cnt_q, err_cnt_d;

    logic           hs, start_acc, last, pend, bad;
    trk_t           ent, chk;
    logic [PKW-1:0] req_key, chk_key;
    logic [DAT-1:0] req_pat, chk_pat;

    assign hs        = vld_q & tcb_rdy;
    assign start_acc = start & (state_q == IDLE);
    assign last      = (n_q == NW'(WRD-1));
    assign ent       = '{vld: hs, ren: ~wen_q, n: n_q};

    // Response tracking: stage 0 is the handshake itself, the entry at
    // stage DLY lines up with rdt/sts. pend means something is still
    // unchecked after this edge.
    if (DLY == 0) begin : g_nodly
        assign chk  = ent;
        assign pend = 1'b0;
    end else begin : g_dly
        trk_t sr_q [DLY];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < DLY; i++) sr_q[i] <= '0;
            end else begin
                sr_q[0] <= ent;
                for (int i = 1; i < DLY; i++) sr_q[i] <= sr_q[i-1];
            end
        end
        assign chk = sr_q[DLY-1];
        always_comb begin
            pend = ent.vld;
            for (int i = 0; i < DLY-1; i++) pend = pend | sr_q[i].vld;
        end
    end

`ifdef TCB_BIST_LFSR_EN
    logic [31:0] lfsr_req_q, lfsr_chk_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_req_q <= LFSR_SEED;
            lfsr_chk_q <= LFSR_SEED;
        end else if (start_acc) begin
            lfsr_req_q <= LFSR_SEED;
            lfsr_chk_q <= LFSR_SEED;
        end else begin
            // Reseed after the last write so the reads replay the sequence.
            if (hs) lfsr_req_q <= (state_q == WRITE && last) ? LFSR_SEED : lfsr_next(lfsr_req_q);
            if (chk.vld && chk.ren) lfsr_chk_q <= lfsr_next(lfsr_chk_q);
        end
    end
    assign req_key = lfsr_req_q;
    assign chk_key = lfsr_chk_q;
`else
    assign req_key = n_q[3:0];
    assign chk_key = chk.n[3:0];
`endif

    tcb_bist_pat #(.DAT(DAT)) u_pat_req (.key(req_key), .pat(req_pat));
    tcb_bist_pat #(.DAT(DAT)) u_pat_chk (.key(chk_key), .pat(chk_pat));

    assign bad = chk.vld & (tcb_sts | (chk.ren & (tcb_rdt != chk_pat)));

    always_comb begin
        state_d   = state_q;
        vld_d     = vld_q;
        wen_d     = wen_q;
        adr_d     = adr_q;
        base_d    = base_q;
        n_d       = n_q;
        gap_d     = gap_q;
        idl_d     = idl_q;
        done_d    = done_q;
        err_cnt_d = err_cnt_q;
        err_adr_d = err_adr_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = WRITE;
                vld_d     = 1'b1;
                wen_d     = 1'b1;
                adr_d     = base;
                base_d    = base;
                idl_d     = idl;
                n_d       = '0;
                gap_d     = '0;
                done_d    = 1'b0;
                err_cnt_d = '0;
                err_adr_d = '0;
            end
            WRITE, READ: begin
                if (hs) begin
                    vld_d = (idl_q == '0);
                    gap_d = idl_q;
                    if (!last) begin
                        n_d   = n_q + NW'(1);
                        adr_d = adr_q + ADR'(BEN);
                    end else if (state_q == WRITE) begin
                        state_d = READ;
                        wen_d   = 1'b0;
                        n_d     = '0;
                        adr_d   = base_q;
                    end else begin
                        // Last read: DLY=0 finishes right here, else drain.
                        vld_d   = 1'b0;
                        state_d = pend ? DRAIN : IDLE;
                        done_d  = ~pend;
                    end
                end else if (!vld_q) begin
                    gap_d = gap_q - IDW'(1);
                    if (gap_q == IDW'(1)) vld_d = 1'b1;
                end
            end
            DRAIN: if (!pend) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (bad) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (err_cnt_q == 16'h0)    err_adr_d = base_q + (ADR'(chk.n) << $clog2(BEN));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            vld_q     <= 1'b0;
            wen_q     <= 1'b0;
            adr_q     <= '0;
            base_q    <= '0;
            n_q       <= '0;
            gap_q     <= '0;
            idl_q     <= '0;
            done_q    <= 1'b0;
            err_cnt_q <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            vld_q     <= vld_d;
            wen_q     <= wen_d;
            adr_q     <= adr_d;
            base_q    <= base_d;
            n_q       <= n_d;
            gap_q     <= gap_d;
            idl_q     <= idl_d;
            done_q    <= done_d;
            err_cnt_q <= err_cnt_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err_cnt = err_cnt_q;
    assign err_adr = err_adr_q;
    assign tcb_vld = vld_q;
    assign tcb_wen = vld_q & wen_q;
    assign tcb_ren = vld_q & ~wen_q;
    assign tcb_adr = adr_q;
    assign tcb_siz = SZW'($clog2(BEN));
    assign tcb_ben = '1;
    assign tcb_wdt = (vld_q & wen_q) ? req_pat : '0;

endmodule

// File: tb/tb_tcb_bist_man.sv
// Directed bench: three BIST instances (DLY = 0, 1, 3) each with a small
// ideal memory that can corrupt a read word or flag sts on chosen words.
module tb_tcb_bist_man;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  idl = 4'd0;
    logic        tog = 1'b0;
    logic        tog_mode = 1'b0;
    logic [31:0] cor_n  = 32'hFFFF_FFFF;
    logic [31:0] sts_wr = 32'hFFFF_FFFF;
    logic [31:0] sts_rd = 32'hFFFF_FFFF;

    logic        start_v [3];
    logic [31:0] base_v  [3];
    logic        busy_v [3], done_v [3], vld_v [3], rdy_v [3], wen_v [3], ren_v [3], sts_v [3];
    logic [15:0] errc_v [3];
    logic [31:0] erra_v [3], adr_v [3], wdt_v [3], rdt_v [3];
    logic [1:0]  siz_v  [3];
    logic [3:0]  ben_v  [3];

    int total = 0;
    int bad   = 0;
    int w0, g0, s0;

    always #5 clk = ~clk;
    always @(negedge clk) tog <= ~tog;

    for (genvar g = 0; g < 3; g++) begin : g_u
        localparam int D = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        logic        hs;
        logic [3:0]  idx;
        logic [31:0] wn;
        logic [32:0] rsp;
        logic [31:0] mem  [16];
        logic [31:0] wadr [64];
        logic [31:0] wdat [64];
        int          wcnt = 0;
        int          gapc = 0, gcount = 0, gbad = 0, sviol = 0;
        logic        in_gap = 1'b0;
        logic        p_vld = 1'b0, p_rdy = 1'b0, p_wen = 1'b0;
        logic [31:0] p_adr = '0, p_wdt = '0;

        tcb_bist_man #(.DLY(D), .ADR(32), .DAT(32), .WRD(4), .IDW(4)) dut (
            .clk(clk), .rst(rst), .start(start_v[g]), .idl(idl), .base(base_v[g]),
            .busy(busy_v[g]), .done(done_v[g]), .err_cnt(errc_v[g]), .err_adr(erra_v[g]),
            .tcb_vld(vld_v[g]), .tcb_rdy(rdy_v[g]), .tcb_wen(wen_v[g]), .tcb_ren(ren_v[g]),
            .tcb_adr(adr_v[g]), .tcb_siz(siz_v[g]), .tcb_ben(ben_v[g]), .tcb_wdt(wdt_v[g]),
            .tcb_rdt(rdt_v[g]), .tcb_sts(sts_v[g])
        );

        assign rdy_v[g] = (g == 1 && tog_mode) ? tog : 1'b1;
        assign hs  = vld_v[g] & rdy_v[g];
        assign idx = adr_v[g][5:2];
        assign wn  = (adr_v[g] - base_v[g]) >> 2;
        assign rsp = {(wen_v[g] ? (wn == sts_wr) : (wn == sts_rd)),
                      mem[idx] ^ ((!wen_v[g] && wn == cor_n) ? 32'h1 : 32'h0)};

        if (D == 0) begin : g_d0
            assign sts_v[g] = rsp[32];
            assign rdt_v[g] = rsp[31:0];
        end else begin : g_dn
            logic [32:0] sr [D];
            always @(posedge clk) begin
                sr[0] <= hs ? rsp : 33'h0;
                for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
            end
            assign sts_v[g] = sr[D-1][32];
            assign rdt_v[g] = sr[D-1][31:0];
        end

        always @(posedge clk) begin
            if (hs && wen_v[g]) begin
                mem[idx]        <= wdt_v[g];
                wadr[wcnt % 64] <= adr_v[g];
                wdat[wcnt % 64] <= wdt_v[g];
                wcnt            <= wcnt + 1;
            end
        end

        // Gap and stall monitors.
        always @(posedge clk) begin
            if (in_gap && vld_v[g]) begin
                gcount <= gcount + 1;
                if (gapc != int'(idl)) gbad <= gbad + 1;
            end
            if (!busy_v[g])            in_gap <= 1'b0;
            else if (hs) begin         in_gap <= 1'b1; gapc <= 0; end
            else if (in_gap && vld_v[g]) in_gap <= 1'b0;
            else if (in_gap)           gapc <= gapc + 1;

            if (p_vld && !p_rdy && (!vld_v[g] || adr_v[g] != p_adr || wen_v[g] != p_wen || wdt_v[g] != p_wdt))
                sviol <= sviol + 1;
            p_vld <= vld_v[g]; p_rdy <= rdy_v[g]; p_wen <= wen_v[g];
            p_adr <= adr_v[g]; p_wdt <= wdt_v[g];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int g, input logic [31:0] b);
        @(negedge clk);
        base_v[g]  = b;
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int lim, input string tag);
        int c = 0;
        while (done_v[g] !== 1'b1 && c < lim) begin
            @(negedge clk);
            c++;
        end
        chk(tag, {31'h0, done_v[g]}, 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            base_v[i]  = 32'h0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy_v[1]}, 32'h0);
        chk("rst_done", {31'h0, done_v[1]}, 32'h0);
        chk("rst_vld",  {31'h0, vld_v[1]},  32'h0);
        chk("rst_ren",  {31'h0, ren_v[1]},  32'h0);
        chk("rst_errc", {16'h0, errc_v[1]}, 32'h0);
        chk("rst_wdt",  wdt_v[1], 32'h0);
        rst = 1'b1;

        // A: idl=0, rdy=1, exact pass length.
        w0 = g_u[1].wcnt;
        pulse(1, 32'h100);
        chk("a_vld",  {31'h0, vld_v[1]}, 32'h1);
        chk("a_wen",  {31'h0, wen_v[1]}, 32'h1);
        chk("a_busy", {31'h0, busy_v[1]}, 32'h1);
        chk("a_adr",  adr_v[1], 32'h100);
        chk("a_wdt",  wdt_v[1], 32'h0302_0100);
        chk("a_siz",  {30'h0, siz_v[1]}, 32'h2);
        chk("a_ben",  {28'h0, ben_v[1]}, 32'hF);
        repeat (8) @(negedge clk);
        chk("a_done_early", {31'h0, done_v[1]}, 32'h0);
        @(negedge clk);
        chk("a_done",  {31'h0, done_v[1]}, 32'h1);
        chk("a_busy0", {31'h0, busy_v[1]}, 32'h0);
        chk("a_errc",  {16'h0, errc_v[1]}, 32'h0);
        chk("a_w1", g_u[1].wdat[(w0+1) % 64], 32'h1312_1110);
        chk("a_w2", g_u[1].wdat[(w0+2) % 64], 32'h2322_2120);
        chk("a_w3", g_u[1].wdat[(w0+3) % 64], 32'h3332_3130);
        chk("a_a3", g_u[1].wadr[(w0+3) % 64], 32'h10C);

        // B: idl=2, rdy toggling, start while busy ignored.
        idl = 4'd2; tog_mode = 1'b1;
        w0 = g_u[1].wcnt; g0 = g_u[1].gcount; s0 = g_u[1].gbad;
        pulse(1, 32'h500);
        repeat (4) @(negedge clk);
        base_v[1] = 32'h900; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0; base_v[1] = 32'h500;
        wait_done(1, 300, "b_done");
        chk("b_errc",  {16'h0, errc_v[1]}, 32'h0);
        chk("b_nwr",   g_u[1].wcnt - w0, 32'd4);
        chk("b_a3",    g_u[1].wadr[(w0+3) % 64], 32'h50C);
        chk("b_gaps",  g_u[1].gcount - g0, 32'd7);
        chk("b_gapbad", g_u[1].gbad - s0, 32'd0);
        chk("b_stall", g_u[1].sviol, 32'd0);
        idl = 4'd0; tog_mode = 1'b0;

        // C: word 2 read corrupted.
        cor_n = 32'd2;
        pulse(1, 32'h100);
        wait_done(1, 100, "c_done");
        chk("c_errc", {16'h0, errc_v[1]}, 32'h1);
        chk("c_erra", erra_v[1], 32'h108);
        cor_n = 32'hFFFF_FFFF;

        // D: sts on write 1 and read 3.
        sts_wr = 32'd1; sts_rd = 32'd3;
        pulse(1, 32'h200);
        wait_done(1, 100, "d_done");
        chk("d_errc", {16'h0, errc_v[1]}, 32'h2);
        chk("d_erra", erra_v[1], 32'h204);
        sts_wr = 32'hFFFF_FFFF; sts_rd = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("d_hold", {31'h0, done_v[1]}, 32'h1);

        // E: accepted start clears status.
        pulse(1, 32'h300);
        chk("e_done0", {31'h0, done_v[1]}, 32'h0);
        chk("e_errc0", {16'h0, errc_v[1]}, 32'h0);
        chk("e_erra0", erra_v[1], 32'h0);
        wait_done(1, 100, "e_done");
        chk("e_errc", {16'h0, errc_v[1]}, 32'h0);

        // F: DLY=0 and DLY=3 with address wrap.
        w0 = g_u[0].wcnt;
        @(negedge clk);
        base_v[0] = 32'hFFFF_FFF8; base_v[2] = 32'hFFFF_FFF8;
        start_v[0] = 1'b1; start_v[2] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; start_v[2] = 1'b0;
        repeat (7) @(negedge clk);
        chk("f0_early", {31'h0, done_v[0]}, 32'h0);
        @(negedge clk);
        chk("f0_done", {31'h0, done_v[0]}, 32'h1);
        repeat (2) @(negedge clk);
        chk("f3_early", {31'h0, done_v[2]}, 32'h0);
        @(negedge clk);
        chk("f3_done", {31'h0, done_v[2]}, 32'h1);
        chk("f0_a1", g_u[0].wadr[(w0+1) % 64], 32'hFFFF_FFFC);
        chk("f0_a2", g_u[0].wadr[(w0+2) % 64], 32'h0);
        chk("f0_a3", g_u[0].wadr[(w0+3) % 64], 32'h4);
        chk("f0_errc", {16'h0, errc_v[0]}, 32'h0);
        chk("f3_errc", {16'h0, errc_v[2]}, 32'h0);

        // G: reset mid-READ with responses in flight on DLY=3.
        pulse(2, 32'h40);
        repeat (6) @(negedge clk);
        chk("g_ren", {31'h0, ren_v[2]}, 32'h1);
        rst = 1'b0;
        #1;
        chk("g_vld",  {31'h0, vld_v[2]},  32'h0);
        chk("g_busy", {31'h0, busy_v[2]}, 32'h0);
        chk("g_done", {31'h0, done_v[2]}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        pulse(2, 32'h80);
        wait_done(2, 100, "g2_done");
        chk("g2_errc", {16'h0, errc_v[2]}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
